// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control-step sequencer:
//   - state_t : control step (IDLE, fetch T0-T2, execute T3-T6)
//   - opcode constants for the ALU group and the MUL/DIV pair
//   - bit positions of the IR fields (opcode, Ra, Rb, Rc)
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6
    } state_t;

    localparam logic [4:0] OPC_ADD  = 5'b00000;
    localparam logic [4:0] OPC_SUB  = 5'b00001;
    localparam logic [4:0] OPC_AND  = 5'b00010;
    localparam logic [4:0] OPC_OR   = 5'b00011;
    localparam logic [4:0] OPC_SHR  = 5'b00100;
    localparam logic [4:0] OPC_SHRA = 5'b00101;
    localparam logic [4:0] OPC_SHL  = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_MUL  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // The three-register ALU group occupies the contiguous range ADD..ROL.
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op <= OPC_ROL);
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-to-16 one-hot register select decoder with enable.
//   en     : when low, all outputs are 0
//   sel    : register index
//   onehot : one-hot select, bit sel set when en is high
module reg_sel_decoder (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_control_sequencer.sv
// Hardwired control-step sequencer: fetch (T0-T2) and execute (T3-T6) strobes
// for 3-register ALU ops and the MUL/DIV ops that write HI/LO.
//   clock, clear    : rising-edge clock, asynchronous active-high reset
//   start           : begin next instruction (sampled in IDLE only)
//   ir              : instruction register contents
//   mem_rdy         : memory read data valid
//   *out / *in      : bus drive enables / register load enables
//   IncPC, Read     : PC increment, memory read
//   Rout, Rin       : one-hot register-file drive / load
//   opcode          : ALU operation select (0 outside the ALU step)
//   busy, done, err : in-progress, completion pulse, error pulse
module muldiv_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [4:0] OP_MUL      = OPC_MUL,
    parameter logic [4:0] OP_DIV      = OPC_DIV
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHighIn,
    output logic        ZLowIn,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  opcode,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic       rout_en, rin_en;
    logic [3:0] rout_sel, rin_sel;

    logic [4:0] ir_opc;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       op_muldiv, op_alu;
    logic       unused_ir;

    assign ir_opc    = ir[OPC_MSB:OPC_LSB];
    assign ir_ra     = ir[RA_MSB:RA_LSB];
    assign ir_rb     = ir[RB_MSB:RB_LSB];
    assign ir_rc     = ir[RC_MSB:RC_LSB];
    assign op_muldiv = (ir_opc == OP_MUL) || (ir_opc == OP_DIV);
    assign op_alu    = is_alu_op(ir_opc);
    assign unused_ir = ^ir[RC_LSB-1:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;          // counter is zero on every T1 entry
        done_d   = 1'b0;
        err_d    = 1'b0;
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ZHighIn  = 1'b0;
        ZLowIn   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        opcode   = '0;
        rout_en  = 1'b0;
        rout_sel = '0;
        rin_en   = 1'b0;
        rin_sel  = '0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = T0;
            end
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZLowIn  = 1'b1;
                state_d = T1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // cnt_q is zero only in the first T1 cycle: PC write-back.
                if (cnt_q == '0) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                if (mem_rdy) begin
                    state_d = T2;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (op_muldiv || op_alu) begin
                    rout_en  = 1'b1;
                    rout_sel = op_muldiv ? ir_ra : ir_rb;
                    Yin      = 1'b1;
                    state_d  = T4;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            T4: begin
                rout_en  = 1'b1;
                rout_sel = op_muldiv ? ir_rb : ir_rc;
                opcode   = ir_opc;
                ZLowIn   = 1'b1;
                ZHighIn  = op_muldiv;
                state_d  = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (op_muldiv) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    rin_en  = 1'b1;
                    rin_sel = ir_ra;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

    reg_sel_decoder u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

    reg_sel_decoder u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

endmodule

// File: tb/tb_muldiv_control_sequencer.sv
// Directed self-checking bench for muldiv_control_sequencer. Outputs are
// sampled on the falling clock edge; inputs change right after sampling.
module tb_muldiv_control_sequencer;

    logic        clock, clear, start, mem_rdy;
    logic [31:0] ir;
    logic        PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
    logic        Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, busy, done, err;
    logic [15:0] Rout, Rin;
    logic [4:0]  opcode;
    logic [17:0] ctrl;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [17:0] C_PCOUT    = 18'd1 << 17;
    localparam logic [17:0] C_ZHIGHOUT = 18'd1 << 16;
    localparam logic [17:0] C_ZLOWOUT  = 18'd1 << 15;
    localparam logic [17:0] C_MDROUT   = 18'd1 << 14;
    localparam logic [17:0] C_MARIN    = 18'd1 << 13;
    localparam logic [17:0] C_PCIN     = 18'd1 << 12;
    localparam logic [17:0] C_MDRIN    = 18'd1 << 11;
    localparam logic [17:0] C_IRIN     = 18'd1 << 10;
    localparam logic [17:0] C_YIN      = 18'd1 << 9;
    localparam logic [17:0] C_HIIN     = 18'd1 << 8;
    localparam logic [17:0] C_LOIN     = 18'd1 << 7;
    localparam logic [17:0] C_ZHIGHIN  = 18'd1 << 6;
    localparam logic [17:0] C_ZLOWIN   = 18'd1 << 5;
    localparam logic [17:0] C_INCPC    = 18'd1 << 4;
    localparam logic [17:0] C_READ     = 18'd1 << 3;
    localparam logic [17:0] C_BUSY     = 18'd1 << 2;
    localparam logic [17:0] C_DONE     = 18'd1 << 1;
    localparam logic [17:0] C_ERR      = 18'd1 << 0;

    localparam logic [17:0] E_ZERO = '0;
    localparam logic [17:0] E_T0   = C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN | C_BUSY;
    localparam logic [17:0] E_T1F  = C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN | C_BUSY;
    localparam logic [17:0] E_T1   = C_READ | C_MDRIN | C_BUSY;
    localparam logic [17:0] E_T2   = C_MDROUT | C_IRIN | C_BUSY;
    localparam logic [17:0] E_T3   = C_YIN | C_BUSY;
    localparam logic [17:0] E_T4M  = C_ZHIGHIN | C_ZLOWIN | C_BUSY;
    localparam logic [17:0] E_T4A  = C_ZLOWIN | C_BUSY;
    localparam logic [17:0] E_T5M  = C_ZLOWOUT | C_LOIN | C_BUSY;
    localparam logic [17:0] E_T5A  = C_ZLOWOUT | C_BUSY;
    localparam logic [17:0] E_T6   = C_ZHIGHOUT | C_HIIN | C_BUSY;

    localparam logic [31:0] IR_DIV = 32'h7930_0000;  // DIV R2,R6
    localparam logic [31:0] IR_ADD = 32'h0091_8000;  // ADD R1,R2,R3
    localparam logic [31:0] IR_BAD = 32'hF800_0000;  // opcode 11111

    assign ctrl = {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin,
                   Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, busy, done, err};

    muldiv_control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .ir       (ir),
        .mem_rdy  (mem_rdy),
        .PCout    (PCout),
        .Zhighout (Zhighout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .MARin    (MARin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .HIin     (HIin),
        .LOin     (LOin),
        .ZHighIn  (ZHighIn),
        .ZLowIn   (ZLowIn),
        .IncPC    (IncPC),
        .Read     (Read),
        .Rout     (Rout),
        .Rin      (Rin),
        .opcode   (opcode),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [17:0] c,
                              input logic [15:0] ro, input logic [15:0] ri,
                              input logic [4:0] op);
        chk({tag, ".ctrl"},   32'(ctrl),   32'(c));
        chk({tag, ".Rout"},   32'(Rout),   32'(ro));
        chk({tag, ".Rin"},    32'(Rin),    32'(ri));
        chk({tag, ".opcode"}, 32'(opcode), 32'(op));
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // DIV R2,R6 with mem_rdy high: done on the 8th edge after start is sampled.
    task automatic run_div(input string tag);
        ir = IR_DIV; mem_rdy = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        expect_cyc({tag, ".T0"}, E_T0, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".T1"}, E_T1F, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".T2"}, E_T2, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".T3"}, E_T3, 16'h0004, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".T4"}, E_T4M, 16'h0040, 16'h0000, 5'b01111);
        tick; expect_cyc({tag, ".T5"}, E_T5M, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".T6"}, E_T6, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".done"}, C_DONE, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc({tag, ".idle"}, E_ZERO, 16'h0000, 16'h0000, 5'd0);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir = '0;

        // Reset: outputs low before any clock edge and while clear is held.
        #1 expect_cyc("rst.async", E_ZERO, 16'h0000, 16'h0000, 5'd0);
        tick; tick;
        expect_cyc("rst.held", E_ZERO, 16'h0000, 16'h0000, 5'd0);
        clear = 1'b0;
        tick; expect_cyc("rst.idle", E_ZERO, 16'h0000, 16'h0000, 5'd0);

        run_div("div");

        // ADD R1,R2,R3: done on the 7th edge; start held at done chains the next.
        ir = IR_ADD; mem_rdy = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        expect_cyc("add.T0", E_T0, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("add.T1", E_T1F, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("add.T2", E_T2, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("add.T3", E_T3, 16'h0004, 16'h0000, 5'd0);
        tick; expect_cyc("add.T4", E_T4A, 16'h0008, 16'h0000, 5'd0);
        tick; expect_cyc("add.T5", E_T5A, 16'h0000, 16'h0002, 5'd0);
        tick; expect_cyc("add.done", C_DONE, 16'h0000, 16'h0000, 5'd0);
        start = 1'b1; mem_rdy = 1'b0;

        // Back-to-back ADD with mem_rdy low for the first 3 T1 cycles.
        tick; start = 1'b0;
        expect_cyc("wait.T0", E_T0, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T1a", E_T1F, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T1b", E_T1, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T1c", E_T1, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T1d", E_T1, 16'h0000, 16'h0000, 5'd0);
        mem_rdy = 1'b1;
        tick; expect_cyc("wait.T2", E_T2, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T3", E_T3, 16'h0004, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T4", E_T4A, 16'h0008, 16'h0000, 5'd0);
        tick; expect_cyc("wait.T5", E_T5A, 16'h0000, 16'h0002, 5'd0);
        tick; expect_cyc("wait.done", C_DONE, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("wait.idle", E_ZERO, 16'h0000, 16'h0000, 5'd0);

        // Memory timeout: 15 T1 cycles, then an err pulse in IDLE.
        ir = IR_ADD; mem_rdy = 1'b0; start = 1'b1;
        tick; start = 1'b0;
        expect_cyc("tmo.T0", E_T0, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("tmo.T1first", E_T1F, 16'h0000, 16'h0000, 5'd0);
        for (int i = 1; i < 15; i++) begin
            tick; expect_cyc($sformatf("tmo.T1_%0d", i), E_T1, 16'h0000, 16'h0000, 5'd0);
        end
        tick; expect_cyc("tmo.err", C_ERR, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("tmo.idle", E_ZERO, 16'h0000, 16'h0000, 5'd0);

        // Illegal opcode: no Yin/Rout in T3, err pulse, no done.
        ir = IR_BAD; mem_rdy = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        expect_cyc("bad.T0", E_T0, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("bad.T1", E_T1F, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("bad.T2", E_T2, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("bad.T3", C_BUSY, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("bad.err", C_ERR, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("bad.idle", E_ZERO, 16'h0000, 16'h0000, 5'd0);

        // Asynchronous clear during T4 of an ADD.
        ir = IR_ADD; mem_rdy = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        tick; tick; tick; tick;
        expect_cyc("clr.T4", E_T4A, 16'h0008, 16'h0000, 5'd0);
        #2 clear = 1'b1;
        #1 expect_cyc("clr.async", E_ZERO, 16'h0000, 16'h0000, 5'd0);
        #1 clear = 1'b0;
        tick; expect_cyc("clr.idle", E_ZERO, 16'h0000, 16'h0000, 5'd0);
        tick; expect_cyc("clr.nopulse", E_ZERO, 16'h0000, 16'h0000, 5'd0);

        run_div("post_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_control_sequencer.md
Name: muldiv_control_sequencer

Overview:
- Hardwired control-step sequencer for the bus datapath. Generates per-cycle control strobes for the fetch (T0-T2) and execute (T3-T6) phases of one instruction.
- Covers 3-register ALU ops and the 2-operand MUL/DIV ops that write the HI/LO pair.
- Sits between the instruction-issue logic (start/done handshake) and the datapath control inputs. Replaces hand-timed testbench strobes.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles T1 waits for mem_rdy before aborting with err.
- OP_MUL, 5'b01110: MUL opcode.
- OP_DIV, 5'b01111: DIV opcode.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  begin fetch/execute of next instruction; sampled in IDLE only.
- ir  in  32  datapath IR contents. Fields: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- mem_rdy  in  1  memory data valid during a read.
- PCout, Zhighout, Zlowout, MDRout  out  1 each  bus drive enables.
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment and memory read.
- Rout  out  16  one-hot register-file bus drive.
- Rin  out  16  one-hot register-file load.
- opcode  out  5  ALU operation select. 0 when no ALU step is active.
- busy  out  1  high from T0 through T6.
- done  out  1  one-cycle pulse when an instruction completes.
- err  out  1  one-cycle pulse on illegal opcode or memory timeout.

Behaviour:
- State is registered. All outputs decode combinationally from state, registered flags, and ir (Moore style).
- On clear, state=IDLE, timeout counter=0, and every output is 0, independent of clock. Clear mid-instruction aborts immediately with no done or err pulse.
- At most one Rout bit is high in any cycle. At most one bus driver is active in any cycle.
- States and transitions:
  - IDLE: all outputs 0. If start=1, go to T0 next edge. start is ignored in every other state.
  - T0 (1 cycle): PCout, MARin, IncPC, ZLowIn.
  - T1 (1..MEM_TIMEOUT cycles):
    - First cycle only: Zlowout, PCin.
    - Every cycle: Read, MDRin.
    - Leave to T2 on the edge where mem_rdy=1.
    - If mem_rdy has not been seen after MEM_TIMEOUT cycles: err pulse, go to IDLE.
    - mem_rdy=1 in the first cycle gives a 1-cycle T1.
  - T2 (1): MDRout, IRin.
  - T3 (1): opcode is decoded from ir here.
    - MUL/DIV: Rout[Ra], Yin.
    - ALU ops (opcodes 00000-01000: add, sub, and, or, shr, shra, shl, ror, rol): Rout[Rb], Yin.
    - Any other opcode: err pulse, go to IDLE, no Yin.
  - T4 (1):
    - MUL/DIV: Rout[Rb], opcode=ir[31:27], ZHighIn, ZLowIn.
    - ALU: Rout[Rc], opcode=ir[31:27], ZLowIn.
  - T5 (1):
    - MUL/DIV: Zlowout, LOin.
    - ALU: Zlowout, Rin[Ra], then done pulse, go to IDLE.
  - T6 (1, MUL/DIV only): Zhighout, HIin, then done pulse, go to IDLE.
- Timing and latency:
  - done is asserted in the cycle after the last execute step, while in IDLE.
  - Latency with mem_rdy=1 immediately: ALU op start to done = 7 cycles; MUL/DIV = 8 cycles.
  - A start held high at the done cycle launches the next fetch on the following edge. There is no bubble beyond IDLE.
- The Rb/Rc decode for R0 uses the plain R0out semantics; Rout[0] is no different from other bits.
- The timeout counter is 4 bits wide (ceil log2 of MEM_TIMEOUT+1) and saturating. It resets on T1 entry.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state enum (IDLE, T0-T6);
  - opcode localparams (ADD=00000 through ROL=01000, MUL=01110, DIV=01111);
  - IR field bit positions.
- One sub-module, reg_sel_decoder: 4-to-16 one-hot decode with enable, instantiated twice (Rout, Rin).

Test Plan:
- DIV R2,R6: start with ir=0x79300000, mem_rdy=1 throughout.
  - T3: Rout=0x0004 and Yin.
  - T4: Rout=0x0040, opcode=01111, ZHighIn, ZLowIn.
  - T5: LOin. T6: HIin.
  - done 8 cycles after start.
- ADD R1,R2,R3 (ir=0x00918000):
  - T3: Rout=0x0004. T4: Rout=0x0008, opcode=0.
  - T5: Rin=0x0002.
  - No HIin or ZHighIn at any point; done at cycle 7.
- Memory wait: mem_rdy low for 3 cycles in T1.
  - Read/MDRin are held 4 cycles.
  - PCin is high only in the first T1 cycle.
  - done is delayed by 3.
- Timeout: mem_rdy never asserted -> err pulse after 15 T1 cycles, IDLE, all outputs 0.
- Illegal opcode 11111 -> err at end of T3, no Yin, no done.
- Clear asserted asynchronously during T4 -> all outputs drop to 0 immediately, state IDLE. The next start runs normally.
